mcdf_slave_node: RTL and testbench

// - Slave channel input stage of MCDF: accepts words from one upstream channel over the

---
 rtl/mcdf_slave_if.sv | 31 +++
 rtl/mcdf_slave_node.sv | 106 ++++++++++
 tb/tb_mcdf_slave_node.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mcdf_slave_if.sv
// Channel-side and arbiter-side handshake bundle of one MCDF slave node.
// The slave modport is the node's view; the master modport is the view of
// whatever drives the channel and acks the head word.
interface mcdf_slave_if #(
    parameter int DW = 32
);
    logic [DW-1:0] ch_data;
    logic          ch_valid;
    logic          ch_ready;
    logic          s2a_req;
    logic [DW-1:0] s2a_data;
    logic          a2s_ack;

    modport slave (
        input  ch_data,
        input  ch_valid,
        output ch_ready,
        output s2a_req,
        output s2a_data,
        input  a2s_ack
    );

    modport master (
        output ch_data,
        output ch_valid,
        input  ch_ready,
        input  s2a_req,
        input  s2a_data,
        output a2s_ack
    );
endinterface

// File: rtl/mcdf_slave_node.sv
// MCDF slave channel input stage: buffers words from one channel in a FIFO,
// offers the head word to the arbiter (request/ack pull), reports free space.
// Optional feature macro MCDF_SLV_CNT_EN adds acc_cnt_o, a saturating 16-bit
// count of accepted words, cleared only by reset.
module mcdf_slave_node #(
    parameter int  DW    = 32,
    parameter int  DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    mcdf_slave_if.slave   bus,
    output logic [AW:0]   margin_o
`ifdef MCDF_SLV_CNT_EN
    ,
    output logic [15:0]   acc_cnt_o
`endif
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    // Storage is deliberately left out of reset; validity is tracked by count.
    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          wr_en;
    logic          rd_en;
    logic          ready;

    // Ready depends only on registered state and control, never on valid,
    // so the channel side sees no combinational loop through the node.
    assign ready = !rst_i && en_i && (count_q != DEPTH_C);
    assign wr_en = bus.ch_valid && ready;
    // An ack on an empty FIFO is ignored.
    assign rd_en = bus.a2s_ack && (count_q != '0);

    assign bus.ch_ready = ready;
    assign bus.s2a_req  = (count_q != '0);
    assign bus.s2a_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign margin_o     = DEPTH_C - count_q;

    // Next-state for pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all buffered words.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage write port.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.ch_data;
        end
    end

`ifdef MCDF_SLV_CNT_EN
    logic [15:0] acc_cnt_q, acc_cnt_d;

    // Accepted-word counter holds at all-ones instead of wrapping.
    always_comb begin
        acc_cnt_d = acc_cnt_q;
        if (wr_en && (acc_cnt_q != 16'hFFFF)) begin
            acc_cnt_d = acc_cnt_q + 16'd1;
        end
    end

    // Accepted-word counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_cnt_q <= '0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
        end
    end

    assign acc_cnt_o = acc_cnt_q;
`endif

endmodule

// File: tb/tb_mcdf_slave_node.sv
// Scoreboard bench for mcdf_slave_node: accepted words are queued when driven
// and compared when acked; occupancy and outputs are checked every cycle.
module tb_mcdf_slave_node;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [AW:0]   margin;
`ifdef MCDF_SLV_CNT_EN
    logic [15:0]   acc_cnt;
    int            exp_acc = 0;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   sb_q [$];

    always #5 clk = ~clk;

    mcdf_slave_if #(.DW(DW)) bus_if ();

    mcdf_slave_node #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (en),
        .bus      (bus_if.slave),
        .margin_o (margin)
`ifdef MCDF_SLV_CNT_EN
        ,
        .acc_cnt_o (acc_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of traffic: drive inputs, check ready/popped word, take the edge, check state.
    task automatic cycle(input logic v, input logic [31:0] d, input logic a);
        logic exp_rdy;
        logic wr;
        logic rd;
        logic [31:0] head;
        bus_if.ch_valid = v;
        bus_if.ch_data  = d;
        bus_if.a2s_ack  = a;
        #1;
        exp_rdy = !rst && en && (sb_q.size() != DEPTH);
        check("ch_ready", 32'(bus_if.ch_ready), 32'(exp_rdy));
        wr = v && exp_rdy;
        rd = a && (sb_q.size() != 0);
        if (rd) begin
            head = sb_q.pop_front();
            check("pop_data", bus_if.s2a_data, head);
        end
        if (wr) begin
            sb_q.push_back(d);
        end
        $display("cyc t=%0t rst=%0b en=%0b valid=%0b data=%0h ack=%0b wr=%0b rd=%0b cnt=%0d",
                 $time, rst, en, v, d, a, wr, rd, sb_q.size());
        @(posedge clk);
        #1;
        if (rst) begin
            sb_q.delete();
        end
`ifdef MCDF_SLV_CNT_EN
        if (rst) begin
            exp_acc = 0;
        end else if (wr && exp_acc < 65535) begin
            exp_acc++;
        end
        check("acc_cnt", 32'(acc_cnt), 32'(exp_acc));
`endif
        check("margin", 32'(margin), 32'(DEPTH - sb_q.size()));
        check("req", 32'(bus_if.s2a_req), 32'(sb_q.size() != 0));
        check("head", bus_if.s2a_data, (sb_q.size() != 0) ? sb_q[0] : 32'h0);
    endtask

    initial begin
        rst             = 1'b1;
        en              = 1'b1;
        bus_if.ch_valid = 1'b0;
        bus_if.ch_data  = '0;
        bus_if.a2s_ack  = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then idle with enable high.
        cycle(1'b1, 32'h1111, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(bus_if.ch_ready), 32'd1);
        check("rst_req", 32'(bus_if.s2a_req), 32'd0);
        check("rst_data", bus_if.s2a_data, 32'h0);
        check("rst_margin", 32'(margin), 32'd32);
        cycle(1'b0, 32'h0, 1'b0);

        // Single word, one-cycle latency, then pop.
        cycle(1'b1, 32'hA5A5_0001, 1'b0);
        check("single_req", 32'(bus_if.s2a_req), 32'd1);
        check("single_data", bus_if.s2a_data, 32'hA5A5_0001);
        check("single_margin", 32'(margin), 32'd31);
        cycle(1'b0, 32'h0, 1'b1);
        check("single_empty_margin", 32'(margin), 32'd32);

        // Fill to full, drop a 33rd word, drain in order.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'(i), 1'b0);
        check("full_ready", 32'(bus_if.ch_ready), 32'd0);
        check("full_margin", 32'(margin), 32'd0);
        cycle(1'b1, 32'd33, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1);

        // Full with simultaneous ack and valid: only the read happens.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0);
        cycle(1'b1, 32'hDEAD, 1'b1);
        check("full_ack_ready", 32'(bus_if.ch_ready), 32'd1);
        check("full_ack_margin", 32'(margin), 32'd1);
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 32'h0, 1'b1);

        // Count 5 with write and ack together: occupancy unchanged.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b0);
        cycle(1'b1, 32'h255, 1'b1);
        check("wr_rd_margin", 32'(margin), 32'd27);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

        // Ack while empty is ignored.
        cycle(1'b0, 32'h0, 1'b1);

        // Disable with 3 words buffered: ready drops at once, words still drain.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h300 + 32'(i), 1'b0);
        en = 1'b0;
        #1;
        check("dis_ready", 32'(bus_if.ch_ready), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3F0, 1'b1);
        en = 1'b1;

        // Reset with 10 words buffered discards them.
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'h400 + 32'(i), 1'b0);
        rst = 1'b1;
        cycle(1'b1, 32'h777, 1'b0);
        rst = 1'b0;
        check("mid_rst_req", 32'(bus_if.s2a_req), 32'd0);
        check("mid_rst_margin", 32'(margin), 32'd32);
`ifdef MCDF_SLV_CNT_EN
        check("mid_rst_acc", 32'(acc_cnt), 32'd0);
`endif
        cycle(1'b1, 32'h500, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
